// File: rtl/hdmi_period_scheduler.sv
// Raster timing and period sequencer for the HDMI TMDS encoders: sync, active video,
// video preamble/guard band and a look-ahead pixel request. Define HDMI_MODE_EN for HDMI periods (else DVI).
module hdmi_period_scheduler #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned HS_POL   = 0,
    parameter int unsigned VS_POL   = 0,
    parameter int unsigned PIX_LAT  = 2
) (
    input  logic        pixel_clk,
    input  logic        rst,
    input  logic        en,
    output logic        active_video,
    output logic        guard_band,
    output logic [1:0]  ch0_ctl,
    output logic [1:0]  ch1_ctl,
    output logic [1:0]  ch2_ctl,
    output logic        pix_req,
    output logic [11:0] pix_x,
    output logic [10:0] pix_y,
    output logic        frame_start,
    output logic        line_start
);

    localparam int unsigned HW       = 12;
    localparam int unsigned VW       = 11;
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned LA_H0    = (H_ACTIVE + PIX_LAT) % H_TOTAL;
    localparam int unsigned LA_V0    = (H_ACTIVE + PIX_LAT >= H_TOTAL) ? 0 : V_TOTAL - 1;
    localparam logic        HS_ON    = 1'(HS_POL);
    localparam logic        VS_ON    = 1'(VS_POL);

    function automatic logic [HW-1:0] step_h(input logic [HW-1:0] h);
        return (h == HW'(H_TOTAL - 1)) ? '0 : h + HW'(1);
    endfunction

    function automatic logic [VW-1:0] step_v(input logic [HW-1:0] h, input logic [VW-1:0] v);
        if (h != HW'(H_TOTAL - 1)) return v;
        return (v == VW'(V_TOTAL - 1)) ? '0 : v + VW'(1);
    endfunction

    logic [HW-1:0] h_q, h_nx, la_h_q, la_h_nx;
    logic [VW-1:0] v_q, v_nx, la_v_q, la_v_nx;
    logic          active_nx, hs_nx, vs_nx, req_nx, fs_nx, ls_nx;
    logic [HW-1:0] px_nx;
    logic [VW-1:0] py_nx;

    // Outputs are decoded from the next position so they describe (h,v) with no lag.
    always_comb begin
        h_nx      = step_h(h_q);
        v_nx      = step_v(h_q, v_q);
        la_h_nx   = step_h(la_h_q);
        la_v_nx   = step_v(la_h_q, la_v_q);
        active_nx = (h_nx < HW'(H_ACTIVE)) && (v_nx < VW'(V_ACTIVE));
        hs_nx     = (h_nx >= HW'(HS_START)) && (h_nx < HW'(HS_END));
        vs_nx     = (v_nx >= VW'(VS_START)) && (v_nx < VW'(VS_END));
        fs_nx     = (h_nx == '0) && (v_nx == '0);
        ls_nx     = (h_nx == '0);
        req_nx    = (la_h_nx < HW'(H_ACTIVE)) && (la_v_nx < VW'(V_ACTIVE));
        px_nx     = req_nx ? la_h_nx : '0;
        py_nx     = req_nx ? la_v_nx : '0;
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            h_q          <= HW'(H_ACTIVE);
            v_q          <= VW'(V_TOTAL - 1);
            la_h_q       <= HW'(LA_H0);
            la_v_q       <= VW'(LA_V0);
            active_video <= 1'b0;
            ch0_ctl      <= {~VS_ON, ~HS_ON};
            pix_req      <= 1'b0;
            pix_x        <= '0;
            pix_y        <= '0;
            frame_start  <= 1'b0;
            line_start   <= 1'b0;
        end else if (en) begin
            h_q          <= h_nx;
            v_q          <= v_nx;
            la_h_q       <= la_h_nx;
            la_v_q       <= la_v_nx;
            active_video <= active_nx;
            ch0_ctl      <= {vs_nx ? VS_ON : ~VS_ON, hs_nx ? HS_ON : ~HS_ON};
            pix_req      <= req_nx;
            pix_x        <= px_nx;
            pix_y        <= py_nx;
            frame_start  <= fs_nx;
            line_start   <= ls_nx;
        end
    end

`ifdef HDMI_MODE_EN
    logic next_line_active, pre_nx, gb_nx;

    // Preamble and guard band occupy the last 10 cycles of a line whose successor is active.
    always_comb begin
        next_line_active = (v_nx == VW'(V_TOTAL - 1)) || (v_nx < VW'(V_ACTIVE - 1));
        pre_nx           = next_line_active && (h_nx >= HW'(H_TOTAL - 10)) && (h_nx <= HW'(H_TOTAL - 3));
        gb_nx            = next_line_active && (h_nx >= HW'(H_TOTAL - 2));
    end

    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            guard_band <= 1'b0;
            ch1_ctl    <= 2'b00;
        end else if (en) begin
            guard_band <= gb_nx;
            ch1_ctl    <= pre_nx ? 2'b01 : 2'b00;
        end
    end
`else
    assign guard_band = 1'b0;
    assign ch1_ctl    = 2'b00;
`endif

    // Only the video preamble is generated, so CTL3/CTL2 stay low.
    assign ch2_ctl = 2'b00;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Self-checking bench for hdmi_period_scheduler: hand vectors, freeze/reset sequences and
// randomized en/rst against a raster-position reference model.
module tb_hdmi_period_scheduler;

    localparam int HA = 16, HF = 4, HS = 4, HB = 12;
    localparam int VA = 4,  VF = 1, VS = 1, VB = 2;
    localparam int LAT = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int START = (VT - 1) * HT + HA;

    logic        pixel_clk, rst, en;
    logic        active_video, guard_band, pix_req, frame_start, line_start;
    logic [1:0]  ch0_ctl, ch1_ctl, ch2_ctl;
    logic [11:0] pix_x;
    logic [10:0] pix_y;

    int n_cmp = 0;
    int n_bad = 0;
    int n = 0;

    hdmi_period_scheduler #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(0), .VS_POL(0), .PIX_LAT(LAT)
    ) dut (
        .pixel_clk(pixel_clk), .rst(rst), .en(en),
        .active_video(active_video), .guard_band(guard_band),
        .ch0_ctl(ch0_ctl), .ch1_ctl(ch1_ctl), .ch2_ctl(ch2_ctl),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
        .frame_start(frame_start), .line_start(line_start)
    );

    initial pixel_clk = 1'b0;
    always #5 pixel_clk = ~pixel_clk;

    typedef struct {
        logic        av, gb, rq, fs, ls;
        logic [1:0]  c0, c1, c2;
        logic [11:0] px;
        logic [10:0] py;
    } exp_t;

    typedef struct {
        int          cyc;
        logic        av, fs, ls, rq;
        int          px, py;
        logic [1:0]  c0;
        logic        gb_h;
        logic [1:0]  c1_h;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference: outputs as a function of how many en-cycles have elapsed since reset.
    function automatic exp_t model(input int cnt);
        exp_t e;
        int p, h, v, q, lh, lv;
        logic follow, pre;
        p  = (START + cnt) % FT;
        h  = p % HT;
        v  = p / HT;
        q  = (p + LAT) % FT;
        lh = q % HT;
        lv = q / HT;
        e.av = (h < HA) && (v < VA);
        e.c0 = {!(v == VA + VF), !(h >= HA + HF && h < HA + HF + HS)};
        follow = ((v + 1) % VT) < VA;
`ifdef HDMI_MODE_EN
        pre  = follow && h >= HT - 10 && h <= HT - 3;
        e.gb = follow && h >= HT - 2;
`else
        pre  = 1'b0;
        e.gb = 1'b0;
`endif
        e.c1 = pre ? 2'b01 : 2'b00;
        e.c2 = 2'b00;
        e.rq = (lh < HA) && (lv < VA);
        e.px = e.rq ? 12'(lh) : 12'd0;
        e.py = e.rq ? 11'(lv) : 11'd0;
        e.fs = (p == 0);
        e.ls = (h == 0);
        return e;
    endfunction

    task automatic check_model();
        exp_t e;
        e = model(n);
        chk("active_video", 32'(active_video), 32'(e.av));
        chk("guard_band",   32'(guard_band),   32'(e.gb));
        chk("ch0_ctl",      32'(ch0_ctl),      32'(e.c0));
        chk("ch1_ctl",      32'(ch1_ctl),      32'(e.c1));
        chk("ch2_ctl",      32'(ch2_ctl),      32'(e.c2));
        chk("pix_req",      32'(pix_req),      32'(e.rq));
        chk("pix_x",        32'(pix_x),        32'(e.px));
        chk("pix_y",        32'(pix_y),        32'(e.py));
        chk("frame_start",  32'(frame_start),  32'(e.fs));
        chk("line_start",   32'(line_start),   32'(e.ls));
        chk("excl_av_gb",   32'(active_video && guard_band), 32'(0));
        chk("excl_pre",     32'((active_video || guard_band) && ch1_ctl != 2'b00), 32'(0));
    endtask

    task automatic tick(input logic e);
        en = e;
        @(posedge pixel_clk);
        if (e && !rst) n++;
        @(negedge pixel_clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        @(negedge pixel_clk);
        @(negedge pixel_clk);
        rst = 1'b0;
        n   = 0;
    endtask

    vec_t tbl[18];

    initial begin
        int cur, cnt, gb_after;
        bit found;
        logic exp_gb;
        logic [1:0] exp_c1;

        rst = 1'b1;
        en  = 1'b0;

        //         cyc  av fs ls rq px py c0     gb c1
        tbl[0]  = '{0,   0, 0, 0, 0, 0, 0, 2'b11, 0, 2'b00};
        tbl[1]  = '{4,   0, 0, 0, 0, 0, 0, 2'b10, 0, 2'b00};
        tbl[2]  = '{10,  0, 0, 0, 0, 0, 0, 2'b11, 0, 2'b01};
        tbl[3]  = '{17,  0, 0, 0, 0, 0, 0, 2'b11, 0, 2'b01};
        tbl[4]  = '{18,  0, 0, 0, 1, 0, 0, 2'b11, 1, 2'b00};
        tbl[5]  = '{20,  1, 1, 1, 1, 2, 0, 2'b11, 0, 2'b00};
        tbl[6]  = '{21,  1, 0, 0, 1, 3, 0, 2'b11, 0, 2'b00};
        tbl[7]  = '{34,  1, 0, 0, 0, 0, 0, 2'b11, 0, 2'b00};
        tbl[8]  = '{35,  1, 0, 0, 0, 0, 0, 2'b11, 0, 2'b00};
        tbl[9]  = '{36,  0, 0, 0, 0, 0, 0, 2'b11, 0, 2'b00};
        tbl[10] = '{54,  0, 0, 0, 1, 0, 1, 2'b11, 1, 2'b00};
        tbl[11] = '{56,  1, 0, 1, 1, 2, 1, 2'b11, 0, 2'b00};
        tbl[12] = '{126, 0, 0, 0, 1, 0, 3, 2'b11, 1, 2'b00};
        tbl[13] = '{154, 0, 0, 0, 0, 0, 0, 2'b11, 0, 2'b00};
        tbl[14] = '{162, 0, 0, 0, 0, 0, 0, 2'b11, 0, 2'b00};
        tbl[15] = '{200, 0, 0, 1, 0, 0, 0, 2'b01, 0, 2'b00};
        tbl[16] = '{220, 0, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00};
        tbl[17] = '{308, 1, 1, 1, 1, 2, 0, 2'b11, 0, 2'b00};

        // Hand-derived vectors, counted in en-cycles from reset release.
        do_reset();
        cur = 0;
        for (int i = 0; i < 18; i++) begin
            while (cur < tbl[i].cyc) begin
                tick(1'b1);
                cur++;
            end
`ifdef HDMI_MODE_EN
            exp_gb = tbl[i].gb_h;
            exp_c1 = tbl[i].c1_h;
`else
            exp_gb = 1'b0;
            exp_c1 = 2'b00;
`endif
            chk($sformatf("vec%0d.active_video", i), 32'(active_video), 32'(tbl[i].av));
            chk($sformatf("vec%0d.frame_start", i),  32'(frame_start),  32'(tbl[i].fs));
            chk($sformatf("vec%0d.line_start", i),   32'(line_start),   32'(tbl[i].ls));
            chk($sformatf("vec%0d.pix_req", i),      32'(pix_req),      32'(tbl[i].rq));
            chk($sformatf("vec%0d.pix_x", i),        32'(pix_x),        32'(tbl[i].px));
            chk($sformatf("vec%0d.pix_y", i),        32'(pix_y),        32'(tbl[i].py));
            chk($sformatf("vec%0d.ch0_ctl", i),      32'(ch0_ctl),      32'(tbl[i].c0));
            chk($sformatf("vec%0d.guard_band", i),   32'(guard_band),   32'(exp_gb));
            chk($sformatf("vec%0d.ch1_ctl", i),      32'(ch1_ctl),      32'(exp_c1));
            chk($sformatf("vec%0d.ch2_ctl", i),      32'(ch2_ctl),      32'(0));
        end

        // en low for 5 cycles while sitting at h=34 of the line before the frame.
        do_reset();
        check_model();
        cnt = 0;
        gb_after = 0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick(!(i >= 18 && i < 23));
            cnt++;
            check_model();
            if (i >= 23 && guard_band) gb_after++;
            if (frame_start) found = 1'b1;
        end
        chk("freeze_found_fs", 32'(found), 32'(1));
        chk("freeze_fs_delay", 32'(cnt), 32'(25));
`ifdef HDMI_MODE_EN
        chk("freeze_gb_rest", 32'(gb_after), 32'(1));
`else
        chk("freeze_gb_rest", 32'(gb_after), 32'(0));
`endif

        // Asynchronous reset at h=8, v=2, then frame_start 20 en-cycles after release.
        do_reset();
        for (int i = 0; i < 100; i++) tick(1'b1);
        check_model();
        #2 rst = 1'b1;
        #1;
        chk("arst.active_video", 32'(active_video), 32'(0));
        chk("arst.guard_band",   32'(guard_band),   32'(0));
        chk("arst.ch0_ctl",      32'(ch0_ctl),      32'(2'b11));
        chk("arst.ch1_ctl",      32'(ch1_ctl),      32'(0));
        chk("arst.pix_req",      32'(pix_req),      32'(0));
        chk("arst.pix_x",        32'(pix_x),        32'(0));
        chk("arst.pix_y",        32'(pix_y),        32'(0));
        chk("arst.frame_start",  32'(frame_start),  32'(0));
        chk("arst.line_start",   32'(line_start),   32'(0));
        @(negedge pixel_clk);
        rst = 1'b0;
        n = 0;
        cnt = 0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick(1'b1);
            cnt++;
            check_model();
            if (frame_start) found = 1'b1;
        end
        chk("arst_found_fs", 32'(found), 32'(1));
        chk("arst_fs_delay", 32'(cnt), 32'(20));

        // Randomized en with occasional resets against the reference model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            else tick($urandom_range(0, 3) != 0);
            check_model();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hdmi_period_scheduler.md
Name: hdmi_period_scheduler

Overview:
- Raster timing and period sequencer feeding the three TMDS channel encoders of the HDMI transmitter.
- Generates per-channel control bits, active-video and guard-band qualifiers, and sync.
- Issues a look-ahead pixel request (with coordinates) to the pattern/pixel source so data arrives aligned with active video.
- Sits between the pattern generator and the encoder/serializer top.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels); must be >= 10
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, hsync active level (0 = active-low)
- VS_POL, 0, vsync active level
- PIX_LAT, 2, cycles between pix_req and the matching active_video cycle; 1..H_FP+H_SYNC+H_BP

Ports:
- pixel_clk  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- en  in  1  clock enable; 0 freezes all state and outputs
- active_video  out  1  current cycle is an active pixel
- guard_band  out  1  current cycle is a video leading guard band
- ch0_ctl  out  2  {vsync, hsync} for channel 0 {d_1,d_0}
- ch1_ctl  out  2  {CTL1, CTL0} for channel 1
- ch2_ctl  out  2  {CTL3, CTL2} for channel 2
- pix_req  out  1  request pixel (pix_x, pix_y) now; consumed PIX_LAT cycles later
- pix_x  out  12  requested pixel column (valid with pix_req, else 0)
- pix_y  out  11  requested pixel row (valid with pix_req, else 0)
- frame_start  out  1  one-cycle pulse at position (0,0)
- line_start  out  1  one-cycle pulse at h=0 of every line

Behaviour:
- H_TOTAL = sum of H_* params; V_TOTAL = sum of V_* params. Counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1).
- Advance only when en=1: h increments; at H_TOTAL-1 h wraps to 0 and v increments; at V_TOTAL-1 v wraps to 0.
- Raster regions:
  - Active: h<H_ACTIVE and v<V_ACTIVE.
  - hsync asserted for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vsync asserted for whole lines v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC).
  - Sync output level = POL when asserted, ~POL otherwise.
- Period classification (video-leading only; data islands out of scope). A line is "followed by active" when the next line index (v+1 mod V_TOTAL) < V_ACTIVE. In such lines:
  - Preamble: h in [H_TOTAL-10, H_TOTAL-3] (8 cycles).
  - Guard band: h in [H_TOTAL-2, H_TOTAL-1] (2 cycles).
- Control bits:
  - Preamble: ch1_ctl=2'b01, ch2_ctl=2'b00.
  - All other cycles: ch1_ctl=ch2_ctl=2'b00.
  - ch0_ctl always = {vsync, hsync}, including during guard band and active.
- All outputs are registered and describe the current position (h,v). Implement by decoding next-state counters, with zero decode lag.
- pix_req=1 iff position PIX_LAT en-cycles ahead is active; pix_x/pix_y are that position. Implement with a second look-ahead counter pair, reset PIX_LAT ahead of the main pair.
- Reset state: h=H_ACTIVE, v=V_TOTAL-1.
  - active_video=0, guard_band=0, ch1_ctl=ch2_ctl=0, ch0_ctl={~VS_POL,~HS_POL}.
  - pix_req=0, pix_x=pix_y=0, frame_start=line_start=0.
- Reset mid-frame: immediate return to reset state; no partial pulses afterwards.
- en=0 on any cycle, including preamble, guard band or active: every output holds its value. There is no skipping; the sequence resumes exactly when en returns to 1.
- Mutual exclusion invariant: active_video, guard_band and preamble never overlap.

Optional Feature:
- HDMI_MODE_EN defined: preamble and guard-band generation as above.
- Undefined (DVI mode):
  - guard_band tied 0; ch1_ctl and ch2_ctl tied 2'b00.
  - Active timing, sync, pix_req and pulses are unchanged.
  - H_BP >= 10 constraint is dropped.

Test Plan (bench params H_ACTIVE=16, H_FP=4, H_SYNC=4, H_BP=12, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=2, PIX_LAT=2; H_TOTAL=36, V_TOTAL=8):
- Reset then en=1 -> reset values as listed; frame_start first pulses 20 cycles after reset release, coincident with active_video=1 and line_start=1.
- Full frame with en=1 -> per line exactly 16 active cycles and hsync low at h=20..23; vsync low only on line v=5; frame_start period 288 cycles.
- HDMI_MODE_EN defined -> on lines v=7,0,1,2, ch1_ctl=01 at h=26..33 and guard_band=1 at h=34,35; on lines 3..6 neither occurs.
- pix_req check -> pix_req rises 2 cycles before each active run with pix_x=0, pix_y=line; pix_req falls 2 cycles before active_video falls; 16 requests per active line.
- en toggled low for 5 cycles during guard band (h=34) -> all outputs frozen; guard_band resumes for exactly the remaining cycle count; active start shifted by 5 cycles.
- rst asserted at h=8, v=2 -> outputs return to reset values asynchronously; the next frame_start is again 20 en-cycles after release. With HDMI_MODE_EN undefined, guard_band and ch1_ctl stay 0 throughout.
